pipe_rr_scheduler: RTL and testbench
====================================

Name: pipe_rr_scheduler

Overview:
- Shares one fixed-latency, non-stallable data pipeline (LATENCY register stages, no enable, no reset) among NUM_REQ requesters.
- Each cycle, picks at most one requester by round-robin and drives its word into the pipeline.
- Carries a valid/tag shadow pipeline alongside the data so each result returns to the requester that issued it.
- Sits between requester blocks (display/clock logic) and a shared pipelined datapath instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data word width.
- LATENCY, 3, stage count of the external pipeline (>=1); must match the instance it drives.
- MAX_OUT, 2, maximum in-flight items per requester (>=1).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*WIDTH  request words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- pipe_in  out  WIDTH  word driven into the external pipeline.
- pipe_out  in  WIDTH  word returned from the external pipeline, LATENCY cycles later.
- rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle per result.
- rsp_data  out  WIDTH  result word; 0 when rsp_valid == 0.
- busy  out  1  high while any shadow stage is valid.

Behaviour:
- Reset (async, while rst high):
  - All shadow valids cleared; all outstanding counters 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - req_ready, rsp_valid and busy all 0; rsp_data 0.
  - Garbage in the external pipeline is ignored because shadow valids are 0.
- Eligibility: req_valid[i] & (cnt[i] < MAX_OUT). cnt[i] is the registered count; a response in the current cycle does not free a slot until the next cycle (no bypass).
- Arbitration (combinational):
  - Search eligible requesters from ptr+1 upward, wrapping modulo NUM_REQ; the first hit is granted.
  - req_ready is one-hot or zero and never asserted for an ineligible requester.
  - pipe_in = granted requester's data, else 0.
- Pointer: on a grant, ptr <= granted index at posedge; unchanged when idle.
- Shadow pipeline (LATENCY stages of {valid, tag}):
  - Stage 0 captures {grant_any, grant_idx} on the same edge the external pipeline captures pipe_in.
  - Stage k captures stage k-1.
- Latency: a word granted in cycle t appears on pipe_out in cycle t+LATENCY.
  - rsp_valid[tag_last] = valid_last; rsp_data = pipe_out when valid_last, else 0.
  - rsp_valid and rsp_data are combinational from registered state plus pipe_out.
- Counters:
  - cnt[i] +1 on grant to i; -1 on response to i.
  - Both in the same cycle: unchanged.
  - cnt width = clog2(MAX_OUT+1); never exceeds MAX_OUT and never underflows.
- Throughput: at most one grant and one response per cycle. Responses arrive in issue order.
- busy = OR of all shadow valids.
- Reset mid-operation: in-flight items are dropped with no responses. The first grant after reset release goes to the lowest-indexed eligible requester.

Optional Feature:
- Macro PIPE_SCHED_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority whenever it is eligible.
  - Round-robin applies only among requesters 1..NUM_REQ-1.
  - ptr updates only on grants to non-zero requesters; ptr reset = NUM_REQ-1.
- Undefined: plain round-robin across all requesters, as described above.

Test Plan:
Defaults are NUM_REQ=4, WIDTH=8, LATENCY=3, MAX_OUT=2, macro undefined, with the external pipeline modelled as 3 registers.
- Single request: after reset, req_valid=0010 with req_data[15:8]=0x5A in cycle 0 -> req_ready=0010 in cycle 0; rsp_valid=0010 and rsp_data=0x5A in cycle 3; busy high cycles 1..3.
- All requesters: req_valid=1111 held, distinct data per requester -> grants 0,1,2,3,0,1,... one per cycle; responses in the same order with matching data, starting at cycle 3.
- Credit limit: only requester 2 valid continuously -> grants in cycles 0,1,4,5,8,9; cnt[2] never exceeds 2; rsp_valid[2] in cycles 3,4,7,8,11,12.
- Reset mid-flight: assert rst in cycle 2 after grants in cycles 0 and 1 -> rsp_valid=0 immediately and no responses afterwards. After release with req_valid=1111, the first grant is requester 0.
- Priority macro: PIPE_SCHED_PRIO0_EN defined, req_valid=1001 held -> grants 0,0,3,3,0,0,3,3. Without the macro, the same stimulus gives 0,3,0,3,...
- Idle: req_valid=0000 for 10 cycles -> req_ready=0, pipe_in=0, and busy drops 3 cycles after the last grant.

Source files
------------

// File: rtl/pipe_rr_scheduler_if.sv
// Requester/pipeline bundle for pipe_rr_scheduler: requests in, one-hot grant out,
// words to/from the shared pipeline, one-hot result strobes back to requesters.
interface pipe_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         pipe_in;
    logic [WIDTH-1:0]         pipe_out;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     busy;

    modport master (
        output req_valid, req_data, pipe_out,
        input  req_ready, pipe_in, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, pipe_out,
        output req_ready, pipe_in, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/pipe_rr_scheduler.sv
// Round-robin share of one fixed-latency pipeline; PIPE_SCHED_PRIO0_EN gives requester 0 strict priority.
// Latency: grant and pipe_in combinational; result strobe LATENCY cycles after grant.
// Backpressure: requester stalls when not granted or when MAX_OUT items are already in flight.
module pipe_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             rst,
    pipe_rr_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               ptr_upd;
    logic [NUM_REQ-1:0] elig;
    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [LATENCY-1:0] sh_vld;
    logic [PTR_W-1:0]   sh_tag [LATENCY];

    logic [NUM_REQ-1:0] req_ready_c;
    logic [WIDTH-1:0]   pipe_in_c;
    logic [NUM_REQ-1:0] rsp_valid_c;
    logic [WIDTH-1:0]   rsp_data_c;

    // Grant is held off during reset so nothing is offered while state is cleared.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] && (cnt[i] < CNT_MAX) && !rst;
        end
    end

    always_comb begin
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
`ifdef PIPE_SCHED_PRIO0_EN
        if (elig[0]) begin
            grant_any = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                cand = 1 + ((int'(ptr) - 1 + k) % (NUM_REQ - 1));
                if (!grant_any && elig[cand[PTR_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[PTR_W-1:0];
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && elig[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
`endif
    end

`ifdef PIPE_SCHED_PRIO0_EN
    assign ptr_upd = grant_any && (grant_idx != '0);
`else
    assign ptr_upd = grant_any;
`endif

    always_comb begin
        req_ready_c = '0;
        pipe_in_c   = '0;
        rsp_valid_c = '0;
        rsp_data_c  = '0;
        if (grant_any) begin
            req_ready_c[grant_idx] = 1'b1;
            pipe_in_c              = bus.req_data[grant_idx*WIDTH +: WIDTH];
        end
        if (sh_vld[LATENCY-1]) begin
            rsp_valid_c[sh_tag[LATENCY-1]] = 1'b1;
            rsp_data_c                     = bus.pipe_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PTR_RST;
        end else if (ptr_upd) begin
            ptr <= grant_idx;
        end
    end

    // Shadow stages track the external pipeline one-for-one so tags line up with pipe_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_vld <= '0;
            for (int k = 0; k < LATENCY; k++) sh_tag[k] <= '0;
        end else begin
            sh_vld[0] <= grant_any;
            sh_tag[0] <= grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                sh_vld[k] <= sh_vld[k-1];
                sh_tag[k] <= sh_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_c[i] && !rsp_valid_c[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (rsp_valid_c[i] && !req_ready_c[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.pipe_in   = pipe_in_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_c;
    assign bus.busy      = |sh_vld;
endmodule

// File: tb/tb_pipe_rr_scheduler.sv
// Bench for pipe_rr_scheduler: external pipeline as LATENCY registers, queue-based reference model.
module tb_pipe_rr_scheduler;
    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 3;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    logic [W-1:0] ext [L];
    always @(posedge clk) begin
        ext[0] <= bus.pipe_in;
        for (int k = 1; k < L; k++) ext[k] <= ext[k-1];
    end
    assign bus.pipe_out = ext[L-1];

    pipe_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L), .MAX_OUT(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int           tag;
        logic [W-1:0] data;
        int           due;
    } item_t;

    item_t        inflight[$];
    int           m_cnt [N];
    int           m_ptr;
    int           cyc;
    int           checks = 0;
    int           passed = 0;
    int           e_gidx;
    logic [N-1:0] e_ready, e_rv;
    logic [W-1:0] e_pin, e_rd;
    logic         e_busy;
    logic [24:0]  obs, expv;

    task automatic model_reset();
        inflight.delete();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = N - 1;
        cyc   = 0;
    endtask

    function automatic bit can_go(int i);
        return bus.req_valid[i] && (m_cnt[i] < M);
    endfunction

    task automatic model_predict();
        int cand;
        e_ready = '0; e_pin = '0; e_rv = '0; e_rd = '0; e_gidx = -1;
        e_busy = (inflight.size() != 0);
        if (inflight.size() != 0 && inflight[0].due == cyc) begin
            e_rv[inflight[0].tag] = 1'b1;
            e_rd = inflight[0].data;
        end
`ifdef PIPE_SCHED_PRIO0_EN
        if (can_go(0)) e_gidx = 0;
        for (int k = 1; k < N; k++) begin
            cand = 1 + ((m_ptr - 1 + k) % (N - 1));
            if (e_gidx < 0 && can_go(cand)) e_gidx = cand;
        end
`else
        for (int k = 1; k <= N; k++) begin
            cand = (m_ptr + k) % N;
            if (e_gidx < 0 && can_go(cand)) e_gidx = cand;
        end
`endif
        if (e_gidx >= 0) begin
            e_ready[e_gidx] = 1'b1;
            e_pin = bus.req_data[e_gidx*W +: W];
        end
    endtask

    task automatic model_commit();
        if (e_rv != '0) begin
            m_cnt[inflight[0].tag]--;
            void'(inflight.pop_front());
        end
        if (e_gidx >= 0) begin
            inflight.push_back('{tag: e_gidx, data: e_pin, due: cyc + L});
            m_cnt[e_gidx]++;
`ifdef PIPE_SCHED_PRIO0_EN
            if (e_gidx != 0) m_ptr = e_gidx;
`else
            m_ptr = e_gidx;
`endif
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_predict();
        obs  = {bus.req_ready, bus.pipe_in, bus.rsp_valid, bus.rsp_data, bus.busy};
        expv = {e_ready, e_pin, e_rv, e_rd, e_busy};
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_data  = $urandom;
        #2;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {bus.req_ready, bus.pipe_in, bus.rsp_valid, bus.rsp_data, bus.busy};
            checks++;
            if (obs !== 25'h0) $display("FAIL reset_outputs c=%0d got=%h exp=0", c, obs);
            else passed++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sample();
        checks++;
        if (bus.req_ready !== 4'b0001) $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready);
        else passed++;
        advance();
    endtask

    task automatic test_single();
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            bus.req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            bus.req_data  = (c == 0) ? 32'h0000_5A00 : 32'h0;
            sample();
            checks++;
            if (obs !== expv) $display("FAIL single c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            checks++;
            if (bus.busy !== 1'(c >= 1 && c <= 3)) $display("FAIL single_busy c=%0d got=%b exp=%b", c, bus.busy, (c >= 1 && c <= 3));
            else passed++;
            if (c == 3) begin
                checks++;
                if ({bus.rsp_valid, bus.rsp_data} !== 12'h25A) $display("FAIL single_rsp got=%h exp=25a", {bus.rsp_valid, bus.rsp_data});
                else passed++;
            end
            advance();
        end
    endtask

    task automatic test_all();
        reset_dut();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h4433_2211;
        for (int c = 0; c < 14; c++) begin
            sample();
            checks++;
            if (obs !== expv) $display("FAIL all_req c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            checks++;
            if (bus.req_ready !== 4'(1 << (c % 4))) $display("FAIL all_req_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4)));
            else passed++;
            if (c >= 3) begin
                checks++;
                if (bus.rsp_valid !== 4'(1 << ((c - 3) % 4))) $display("FAIL all_req_rsp c=%0d got=%b exp=%b", c, bus.rsp_valid, 4'(1 << ((c - 3) % 4)));
                else passed++;
            end
            advance();
        end
    endtask

    task automatic test_credit();
        int outstanding;
        outstanding = 0;
        reset_dut();
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 14; c++) begin
            bus.req_data = $urandom;
            sample();
            checks++;
            if (obs !== expv) $display("FAIL credit c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            checks++;
            if (bus.req_ready[2] !== 1'((c % 4) < 2)) $display("FAIL credit_grant c=%0d got=%b exp=%b", c, bus.req_ready[2], ((c % 4) < 2));
            else passed++;
            checks++;
            if (bus.rsp_valid[2] !== 1'(c >= 3 && ((c - 3) % 4) < 2)) $display("FAIL credit_rsp c=%0d got=%b", c, bus.rsp_valid[2]);
            else passed++;
            outstanding += int'(bus.req_ready[2]) - int'(bus.rsp_valid[2]);
            checks++;
            if (outstanding > M || outstanding < 0) $display("FAIL credit_limit c=%0d got=%0d exp<=%0d", c, outstanding, M);
            else passed++;
            advance();
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'hD4C3_B2A1;
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (obs !== expv) $display("FAIL midrst_pre c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            advance();
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            obs = {bus.req_ready, bus.pipe_in, bus.rsp_valid, bus.rsp_data, bus.busy};
            checks++;
            if (obs !== 25'h0) $display("FAIL midrst_held c=%0d got=%h exp=0", c, obs);
            else passed++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            sample();
            checks++;
            if (obs !== expv) $display("FAIL midrst_post c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            if (c == 0) begin
                checks++;
                if (bus.req_ready !== 4'b0001) $display("FAIL midrst_first got=%b exp=0001", bus.req_ready);
                else passed++;
            end
            if (c < 3) begin
                checks++;
                if (bus.rsp_valid !== 4'b0000) $display("FAIL midrst_stale c=%0d got=%b exp=0000", c, bus.rsp_valid);
                else passed++;
            end
            advance();
        end
    endtask

    task automatic test_prio();
        logic [3:0] seq [8];
`ifdef PIPE_SCHED_PRIO0_EN
        seq = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
`else
        seq = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
        reset_dut();
        bus.req_valid = 4'b1001;
        bus.req_data  = 32'hD000_00A0;
        for (int c = 0; c < 8; c++) begin
            sample();
            checks++;
            if (obs !== expv) $display("FAIL prio c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            checks++;
            if (bus.req_ready !== seq[c]) $display("FAIL prio_seq c=%0d got=%b exp=%b", c, bus.req_ready, seq[c]);
            else passed++;
            advance();
        end
    endtask

    task automatic test_idle();
        bus.req_valid = 4'b0000;
        bus.req_data  = $urandom;
        for (int c = 0; c < 10; c++) begin
            sample();
            checks++;
            if (obs !== expv) $display("FAIL idle c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            checks++;
            if ({bus.req_ready, bus.pipe_in, bus.busy} !== {12'h0, 1'(c < 3)}) $display("FAIL idle_quiet c=%0d got=%h exp=%h", c, {bus.req_ready, bus.pipe_in, bus.busy}, {12'h0, 1'(c < 3)});
            else passed++;
            advance();
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 79) == 0) reset_dut();
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.req_data  = $urandom;
            sample();
            checks++;
            if (obs !== expv) $display("FAIL random c=%0d got=%h exp=%h", c, obs, expv);
            else passed++;
            advance();
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        model_reset();
        test_reset();
        test_single();
        test_all();
        test_credit();
        test_reset_mid();
        test_prio();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
